// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch sequencer for a synchronous instruction ROM with a 2-entry decode buffer.
// Optional feature macro FETCH_PERF_CNT_EN adds the fetch_count/stall_count performance counters.
module instr_fetch_ctrl #(
   parameter int WIDTH = 32,
   parameter int ROM_ADDR_BITS = 12,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             halt,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             rom_en,
   output logic [WIDTH-1:0] rom_addr,
   input  logic [WIDTH-1:0] rom_data,
   output logic             inst_valid,
   output logic [WIDTH-1:0] inst,
   output logic [WIDTH-1:0] inst_pc,
   input  logic             inst_ready,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]      fetch_count,
   output logic [31:0]      stall_count,
`endif
   output logic             busy
);
   localparam int AW = ROM_ADDR_BITS;
   typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;
   state_t state, state_n;
   logic [AW-1:0] pc, pc_n, iss_pc, ret_pc;
   logic in_flight, ret_epoch, epoch, live, pop, pop_buf, push, issue, hd, wr;
   logic [1:0] count, count_n;
   logic [WIDTH-1:0] buf_data [2];
   logic [AW-1:0] buf_pc [2];
   logic unused_redirect_bits;
   assign unused_redirect_bits = ^redirect_pc[WIDTH-1:AW];
   assign rom_addr = WIDTH'(iss_pc);
   // A returning word bypasses an empty buffer so decode sees it the cycle it arrives;
   // the next issue is decided from next-cycle occupancy so the buffer can never overflow.
   always_comb begin
      live = in_flight & (ret_epoch == epoch);
      inst_valid = (count != 2'd0) | live;
      inst = (count != 2'd0) ? buf_data[hd] : live ? rom_data : '0;
      inst_pc = (count != 2'd0) ? WIDTH'(buf_pc[hd]) : live ? WIDTH'(ret_pc) : '0;
      pop = inst_valid & inst_ready & ~redirect_valid;
      pop_buf = pop & (count != 2'd0);
      push = live & ~redirect_valid & ~(pop & (count == 2'd0));
      wr = hd ^ count[0];
      count_n = redirect_valid ? 2'd0 : count + {1'b0, push} - {1'b0, pop_buf};
      state_n = (state == IDLE) ? (start ? FETCH : IDLE) : (halt ? HALTED : FETCH);
      pc_n = redirect_valid ? redirect_pc[AW-1:0] : pc;
      issue = (state_n == FETCH) & ((count_n + {1'b0, rom_en & ~redirect_valid}) < 2'd2);
      busy = in_flight | (count != 2'd0);
   end
   // Fetch FSM, program counter, registered ROM request and return/epoch tracking
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pc <= RESET_PC[AW-1:0];
         rom_en <= 1'b0;
         iss_pc <= '0;
         in_flight <= 1'b0;
         ret_pc <= '0;
         ret_epoch <= 1'b0;
         epoch <= 1'b0;
         hd <= 1'b0;
         count <= 2'd0;
      end else begin
         state <= state_n;
         pc <= issue ? pc_n + 1'b1 : pc_n;
         rom_en <= issue;
         iss_pc <= issue ? pc_n : '0;
         in_flight <= rom_en;
         ret_pc <= iss_pc;
         ret_epoch <= epoch;
         epoch <= epoch ^ redirect_valid;
         hd <= hd ^ pop_buf;
         count <= count_n;
      end
   end
   // Buffer storage: the tail slot is the head offset by the current count
   always_ff @(posedge clk) begin
      if (push) begin
         buf_data[wr] <= rom_data;
         buf_pc[wr] <= ret_pc;
      end
   end
`ifdef FETCH_PERF_CNT_EN
   // Saturating counters of accepted handshakes and back-pressured cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count <= '0;
         stall_count <= '0;
      end else begin
         if (inst_valid && inst_ready && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
         if (inst_valid && !inst_ready && stall_count != '1) stall_count <= stall_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: scoreboard bench for instr_fetch_ctrl with a ROM model holding ROM[n]=n+0x100.
module tb_instr_fetch_ctrl;
   localparam int WIDTH = 32;
   localparam int AB = 12;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, halt = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
   logic [WIDTH-1:0] redirect_pc = '0, rom_data = '0;
   logic rom_en, inst_valid, busy;
   logic [WIDTH-1:0] rom_addr, inst, inst_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count, stall_count;
`endif
   int n_vec = 0, n_err = 0;
   logic [WIDTH-1:0] q_pc[$], q_in[$];

   instr_fetch_ctrl #(.WIDTH(WIDTH), .ROM_ADDR_BITS(AB)) dut (
      .clk(clk), .reset(reset), .start(start), .halt(halt),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
`ifdef FETCH_PERF_CNT_EN
      .fetch_count(fetch_count), .stall_count(stall_count),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: data valid the cycle after the enable
   always @(posedge clk) if (rom_en) rom_data <= rom_addr + 32'h100;

   task automatic check(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_run(input int pc0, input int n);
      for (int i = 0; i < n; i++) begin
         q_pc.push_back(WIDTH'((pc0 + i) % (1 << AB)));
         q_in.push_back(WIDTH'((pc0 + i) % (1 << AB)) + 32'h100);
      end
   endtask

   task automatic reset_dut();
      reset = 1'b1; halt = 1'b0; start = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while ((busy || q_pc.size() != 0) && k < 40) begin
         step();
         k++;
      end
      check(tag, WIDTH'(q_pc.size()), '0);
      check({tag, "_busy"}, WIDTH'(busy), '0);
      q_pc.delete();
      q_in.delete();
   endtask

   // Scoreboard: every accepted transfer must match the oldest expected word
   always @(negedge clk) begin
      if (!reset && inst_valid && inst_ready && !redirect_valid) begin
         if (q_pc.size() == 0) check("extra_xfer", inst_pc, '1);
         else begin
            check("inst_pc", inst_pc, q_pc.pop_front());
            check("inst", inst, q_in.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1);
   end

   initial begin
      step();
      step();
      check("rst_rom_en", rom_en, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_valid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      // streaming, halt, resume
      inst_ready = 1'b1; start = 1'b1; expect_run(0, 6);
      step(); start = 1'b0;
      check("lat_rom_en", rom_en, 1);
      check("lat_addr0", rom_addr, 0);
      check("lat_nvalid", inst_valid, 0);
      step();
      check("lat_addr1", rom_addr, 1);
      check("lat_valid", inst_valid, 1);
      repeat (4) step();
      check("seq_addr5", rom_addr, 5);
      halt = 1'b1;
      step();
      check("halt_en", rom_en, 0);
      check("halt_busy", busy, 1);
      step();
      check("halt_idle", busy, 0);
      expect_run(6, 2); halt = 1'b0;
      step();
      check("resume_addr", rom_addr, 6);
      step(); halt = 1'b1;
      check("resume_addr7", rom_addr, 7);
      drain("s1_drain");
      // back-pressure fills exactly two entries
      reset_dut(); start = 1'b1; expect_run(0, 4);
      step(); start = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         check("bp_inst", inst, 32'h100);
         check("bp_pc", inst_pc, 0);
         if (i >= 2) check("bp_rom_en", rom_en, 0);
         step();
      end
      inst_ready = 1'b1;
      step();
      check("bp_resume", rom_addr, 2);
      step(); halt = 1'b1;
      check("bp_addr3", rom_addr, 3);
      drain("s2_drain");
      // redirects with buffered and in-flight stale words
      reset_dut(); start = 1'b1;
      step(); start = 1'b0;
      step();
      step();
      check("rd_busy", busy, 1);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_1020; inst_ready = 1'b1; expect_run('h20, 1);
      step(); redirect_valid = 1'b0;
      check("rd_flush", inst_valid, 0);
      check("rd_addr", rom_addr, 32'h20);
      step();
      check("rd_addr1", rom_addr, 32'h21);
      step();
      check("rd2_en", rom_en, 1);
      redirect_valid = 1'b1; redirect_pc = 32'h40; expect_run('h40, 2);
      step(); redirect_valid = 1'b0;
      check("rd2_stale", inst_valid, 0);
      check("rd2_addr", rom_addr, 32'h40);
      step(); halt = 1'b1;
      drain("s3_drain");
      // PC wrap at the top of the ROM
      reset_dut(); inst_ready = 1'b1; start = 1'b1;
      step(); start = 1'b0;
      step();
      redirect_valid = 1'b1; redirect_pc = 32'hFFF; expect_run('hFFF, 3);
      step(); redirect_valid = 1'b0;
      check("wrap_top", rom_addr, 32'hFFF);
      step();
      check("wrap_zero", rom_addr, 0);
      step(); halt = 1'b1;
      drain("s4_drain");
      // reset while a word is in flight
      reset_dut(); inst_ready = 1'b1; start = 1'b1;
      step(); start = 1'b0;
      check("rf_en", rom_en, 1);
      reset = 1'b1;
      step(); reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("rf_valid", inst_valid, 0);
         check("rf_rom_en", rom_en, 0);
         step();
      end
      start = 1'b1; expect_run(0, 2);
      step(); start = 1'b0;
      step(); halt = 1'b1;
      drain("s5_drain");
`ifdef FETCH_PERF_CNT_EN
      // ten transfers, three stalled cycles
      reset_dut(); inst_ready = 1'b1; start = 1'b1; expect_run(0, 10);
      step(); start = 1'b0;
      step();
      step(); inst_ready = 1'b0;
      repeat (3) step();
      inst_ready = 1'b1;
      repeat (7) step();
      halt = 1'b1;
      drain("s6_drain");
      check("fetch_count", fetch_count, 32'd10);
      check("stall_count", stall_count, 32'd3);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
